non_restore_divider_param: RTL

Parametrised, iterative non-restoring divider. It supports unsigned and two's-complement signed operation and exposes a start/busy/done handshake. It flags divide-by-zero and signed overflow. The block is a drop-in successor to the fixed 4-bit divider used in the toy datapath, producing one quotient bit per clock.

---
 rtl/non_restore_divider_param.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/non_restore_divider_param.sv
// Iterative non-restoring divider, one quotient bit per clock, unsigned or two's-complement.
// Flags divide-by-zero and signed MIN/-1 overflow alongside the single-cycle done pulse.
module non_restore_divider_param #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StCorr} state_e;

    state_e           r_state, w_state_d;
    logic [WIDTH:0]   r_a, w_a_d;
    logic [WIDTH-1:0] r_q, w_q_d;
    logic [WIDTH-1:0] r_d, w_d_d;
    logic [CW-1:0]    r_count, w_count_d;
    logic             r_neg_q, w_neg_q_d;
    logic             r_neg_r, w_neg_r_d;
    logic             r_zero, w_zero_d;
    logic             r_ovf_pend, w_ovf_pend_d;
    logic [WIDTH-1:0] r_dvd_raw, w_dvd_raw_d;
    logic             r_busy, w_busy_d;
    logic             r_done, w_done_d;
    logic [WIDTH-1:0] r_quot, w_quot_d;
    logic [WIDTH-1:0] r_rem, w_rem_d;
    logic             r_dbz, w_dbz_d;
    logic             r_ovf, w_ovf_d;

    logic             w_sgn;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_d_ext;
    logic [WIDTH:0]   w_a_step;
    logic [WIDTH-1:0] w_q_step;
    logic [WIDTH-1:0] w_rem_mag;
    logic [WIDTH-1:0] w_quot_s;
    logic [WIDTH-1:0] w_rem_s;

    assign w_sgn     = SIGNED_EN && signed_mode;
    assign w_dvd_neg = w_sgn && dividend[WIDTH-1];
    assign w_dvs_neg = w_sgn && divisor[WIDTH-1];
    // MIN negates to itself, which reads correctly as an unsigned magnitude.
    assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag = w_dvs_neg ? -divisor : divisor;

    assign w_shift  = {r_a[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_d_ext  = {1'b0, r_d};
    assign w_a_step = r_a[WIDTH] ? (w_shift + w_d_ext) : (w_shift - w_d_ext);
    assign w_q_step = {r_q[WIDTH-2:0], ~w_a_step[WIDTH]};

    assign w_rem_mag = r_a[WIDTH] ? (r_a[WIDTH-1:0] + r_d) : r_a[WIDTH-1:0];
    assign w_quot_s  = r_neg_q ? -r_q : r_q;
    assign w_rem_s   = r_neg_r ? -w_rem_mag : w_rem_mag;

    always_comb begin
        w_state_d    = r_state;
        w_a_d        = r_a;
        w_q_d        = r_q;
        w_d_d        = r_d;
        w_count_d    = r_count;
        w_neg_q_d    = r_neg_q;
        w_neg_r_d    = r_neg_r;
        w_zero_d     = r_zero;
        w_ovf_pend_d = r_ovf_pend;
        w_dvd_raw_d  = r_dvd_raw;
        w_busy_d     = r_busy;
        w_done_d     = 1'b0;
        w_quot_d     = r_quot;
        w_rem_d      = r_rem;
        w_dbz_d      = r_dbz;
        w_ovf_d      = r_ovf;

        case (r_state)
            StIdle: begin
                if (start) begin
                    w_busy_d     = 1'b1;
                    w_dbz_d      = 1'b0;
                    w_ovf_d      = 1'b0;
                    w_dvd_raw_d  = dividend;
                    w_zero_d     = (divisor == '0);
                    w_ovf_pend_d = w_sgn && (dividend == MinVal) && (divisor == '1);
                    w_neg_q_d    = w_dvd_neg ^ w_dvs_neg;
                    w_neg_r_d    = w_dvd_neg;
                    w_a_d        = '0;
                    w_q_d        = w_dvd_mag;
                    w_d_d        = w_dvs_mag;
                    w_count_d    = CW'(WIDTH);
                    w_state_d    = (divisor == '0) ? StCorr : StCalc;
                end
            end
            StCalc: begin
                w_a_d     = w_a_step;
                w_q_d     = w_q_step;
                w_count_d = r_count - CW'(1);
                if (r_count == CW'(1)) begin
                    w_state_d = StCorr;
                end
            end
            StCorr: begin
                w_busy_d  = 1'b0;
                w_done_d  = 1'b1;
                w_state_d = StIdle;
                if (r_zero) begin
                    w_quot_d = '1;
                    w_rem_d  = r_dvd_raw;
                    w_dbz_d  = 1'b1;
                end else begin
                    w_quot_d = w_quot_s;
                    w_rem_d  = w_rem_s;
                    w_ovf_d  = r_ovf_pend;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state    <= StIdle;
            r_a        <= '0;
            r_q        <= '0;
            r_d        <= '0;
            r_count    <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_zero     <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_dvd_raw  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_dbz      <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_a        <= w_a_d;
            r_q        <= w_q_d;
            r_d        <= w_d_d;
            r_count    <= w_count_d;
            r_neg_q    <= w_neg_q_d;
            r_neg_r    <= w_neg_r_d;
            r_zero     <= w_zero_d;
            r_ovf_pend <= w_ovf_pend_d;
            r_dvd_raw  <= w_dvd_raw_d;
            r_busy     <= w_busy_d;
            r_done     <= w_done_d;
            r_quot     <= w_quot_d;
            r_rem      <= w_rem_d;
            r_dbz      <= w_dbz_d;
            r_ovf      <= w_ovf_d;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule
